mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the core's single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It accepts one request at a time on valid/ready channels, forwards it to the memory port, and routes the response back to the owner. Ties are broken round-robin. It sits between the IFU/LSU pipeline stages and the memory/bus interface.

## Interface
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width; wmask width is DATA_WIDTH/8

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- ifu_req_valid / ifu_req_ready  in / out  1  IFU request handshake
- ifu_req_addr  in  ADDR_WIDTH  IFU fetch address
- ifu_resp_valid / ifu_resp_ready  out / in  1  IFU response handshake
- ifu_resp_rdata  out  DATA_WIDTH  fetched data
- lsu_req_valid / lsu_req_ready  in / out  1  LSU request handshake
- lsu_req_addr  in  ADDR_WIDTH; lsu_req_wen  in  1; lsu_req_wdata  in  DATA_WIDTH; lsu_req_wmask  in  DATA_WIDTH/8
- lsu_resp_valid / lsu_resp_ready  out / in  1  LSU response handshake
- lsu_resp_rdata  out  DATA_WIDTH  load data (don't-care on writes)
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask  out  as LSU widths
- mem_resp_valid / mem_resp_ready  in / out  1  memory response handshake
- mem_resp_rdata  in  DATA_WIDTH

## Operation
- FSM states: IDLE, REQ, RESP. Registers: state, owner (IFU=0, LSU=1), last (last owner), payload (addr, wen, wdata, wmask).
- IDLE: arbitrate among valid requesters. One valid → it wins. Both valid → winner is the port != last. Winner's req_ready=1 (loser's=0). On handshake: capture payload, owner<=winner, state<=REQ. No requester valid → stay.
- IFU payload capture forces wen=0, wdata=0, wmask=0.
- REQ: mem_req_valid=1 with registered payload (stable until accepted). On mem_req_ready → RESP.
- RESP: owner's resp_valid = mem_resp_valid, owner's resp_rdata = mem_resp_rdata, mem_resp_ready = owner's resp_ready. Non-owner resp_valid=0. On mem_resp_valid & mem_resp_ready: last<=owner, state<=IDLE.
- Both req_ready=0 in REQ and RESP; exactly one transaction outstanding.
- mem_resp_valid outside RESP is ignored (mem_resp_ready=0).

## Timing
- Reset (async, any state): state=IDLE, owner=0, last=1 (first tie goes to IFU), payload=0. All valid/ready outputs 0 except the combinational req_ready in IDLE, which follows the arbitration rule once reset deasserts.
- Request accept: ready combinational in IDLE, same cycle as valid.
- mem_req_valid rises the cycle after acceptance; minimum accept-to-mem-request latency 1 cycle.
- Response path combinational: resp_valid to owner same cycle as mem_resp_valid; zero added latency.
- Minimum turnaround: accept (IDLE) → REQ → RESP → IDLE = next accept 3 cycles after previous accept if memory is ready immediately.
- Owner's resp_ready low: mem_resp_ready stays low, FSM holds RESP (backpressure to memory).
- Requester deasserting valid before acceptance is legal; nothing captured.
- Reset mid-transaction drops it; no response delivered.

## Structure
- Shared package: state enum (IDLE/REQ/RESP), owner constants (IFU=0, LSU=1), rst_enable constant (active-low).
- One sub-module natural: arb_rr2, combinational two-input round-robin picker (inputs: two valids, last; outputs: grant one-hot). Everything else inline.

## Test plan
- IFU only: ifu read 0x8000_0000, mem returns 0xDEAD_BEEF after 2 cycles → ifu_resp_rdata=0xDEAD_BEEF, lsu_resp_valid never 1, mem_req_wen=0, wmask=0.
- Tie: both valid in first cycle after reset → IFU granted first; both held valid → next grant LSU, then IFU (alternating).
- LSU write addr 0x8000_0100, wdata 0x1234_5678, wmask 0xF, mem_req_ready low 3 cycles → mem_req_* stable across stall, accepted on 4th cycle, LSU response delivered.
- Response backpressure: ifu_resp_ready low 2 cycles during mem_resp_valid → mem_resp_ready low, FSM in RESP, both req_ready=0.
- Async reset asserted in RESP mid-transaction → all valids 0 immediately; after release, pending IFU request accepted with no stale response.
- Spurious mem_resp_valid in IDLE → ignored, no resp_valid to either port.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OWNER_IFU  = 1'b0;
    localparam logic OWNER_LSU  = 1'b1;
    localparam logic RST_ENABLE = 1'b0;

endpackage

// File: rtl/mem_arbiter_if.sv
// Valid/ready request + response channel; master issues requests, slave answers.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_wen;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [MASK_WIDTH-1:0] req_wmask;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-input round-robin picker: on a tie the port that did not win last time is granted.
module arb_rr2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = valid0 & (~valid1 | last);
        grant[1] = valid1 & (~valid0 | ~last);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU; one transaction in flight.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   ifu,
    mem_arbiter_if.slave   lsu,
    mem_arbiter_if.master  mem
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
    logic [1:0]            grant;

    arb_rr2 u_arb (
        .valid0 (ifu.req_valid),
        .valid1 (lsu.req_valid),
        .last   (last_q),
        .grant  (grant)
    );

    // Read data is broadcast; only the owner's resp_valid qualifies it.
    assign ifu.resp_rdata = mem.resp_rdata;
    assign lsu.resp_rdata = mem.resp_rdata;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        ifu.req_ready  = 1'b0;
        lsu.req_ready  = 1'b0;
        ifu.resp_valid = 1'b0;
        lsu.resp_valid = 1'b0;
        mem.req_valid  = 1'b0;
        mem.req_addr   = addr_q;
        mem.req_wen    = wen_q;
        mem.req_wdata  = wdata_q;
        mem.req_wmask  = wmask_q;
        mem.resp_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ifu.req_ready = grant[0];
                lsu.req_ready = grant[1];
                if (grant[0]) begin
                    // Fetches are always reads, whatever the IFU drives on the write fields.
                    state_d = ST_REQ;
                    owner_d = OWNER_IFU;
                    addr_d  = ifu.req_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                end else if (grant[1]) begin
                    state_d = ST_REQ;
                    owner_d = OWNER_LSU;
                    addr_d  = lsu.req_addr;
                    wen_d   = lsu.req_wen;
                    wdata_d = lsu.req_wdata;
                    wmask_d = lsu.req_wmask;
                end
            end
            ST_REQ: begin
                mem.req_valid = 1'b1;
                if (mem.req_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (owner_q == OWNER_IFU) begin
                    ifu.resp_valid = mem.resp_valid;
                    mem.resp_ready = ifu.resp_ready;
                end else begin
                    lsu.resp_valid = mem.resp_valid;
                    mem.resp_ready = lsu.resp_ready;
                end
                if (mem.resp_valid && mem.resp_ready) begin
                    last_d  = owner_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_IFU;
            last_q  <= OWNER_LSU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic lsu_seen;
    logic mon_lsu;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifu_if ();
    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) lsu_if ();
    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .ifu (ifu_if.slave),
        .lsu (lsu_if.slave),
        .mem (mem_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_lsu && lsu_if.resp_valid) lsu_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grants(input string tag, input logic g_ifu, input logic g_lsu);
        #1;
        check({tag, "_ifu_ready"}, ifu_if.req_ready, g_ifu);
        check({tag, "_lsu_ready"}, lsu_if.req_ready, g_lsu);
    endtask

    // Runs an accepted-on-next-edge transaction with an immediately ready memory.
    task automatic xact(input string tag, input logic own, input logic [31:0] exp_addr,
                        input logic [31:0] rdata);
        step();
        check({tag, "_req_valid"}, mem_if.req_valid, 1'b1);
        check({tag, "_req_addr"}, mem_if.req_addr, exp_addr);
        check({tag, "_busy_ready"}, {ifu_if.req_ready, lsu_if.req_ready}, 2'b00);
        mem_if.req_ready = 1'b1;
        step();
        mem_if.req_ready  = 1'b0;
        mem_if.resp_valid = 1'b1;
        mem_if.resp_rdata = rdata;
        #1;
        check({tag, "_resp_valid"}, {lsu_if.resp_valid, ifu_if.resp_valid},
              own ? 2'b10 : 2'b01);
        check({tag, "_rdata"}, own ? lsu_if.resp_rdata : ifu_if.resp_rdata, rdata);
        step();
        mem_if.resp_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        lsu_seen = 1'b0;
        mon_lsu  = 1'b0;
        rst      = 1'b0;
        ifu_if.req_valid  = 1'b0; ifu_if.req_addr  = '0; ifu_if.req_wen = 1'b0;
        ifu_if.req_wdata  = '0;   ifu_if.req_wmask = '0; ifu_if.resp_ready = 1'b1;
        lsu_if.req_valid  = 1'b0; lsu_if.req_addr  = '0; lsu_if.req_wen = 1'b0;
        lsu_if.req_wdata  = '0;   lsu_if.req_wmask = '0; lsu_if.resp_ready = 1'b1;
        mem_if.req_ready  = 1'b0; mem_if.resp_valid = 1'b0; mem_if.resp_rdata = '0;

        // Reset state
        step();
        step();
        check("rst_req_valid", mem_if.req_valid, 1'b0);
        check("rst_resp_valid", {ifu_if.resp_valid, lsu_if.resp_valid}, 2'b00);
        check("rst_mem_resp_ready", mem_if.resp_ready, 1'b0);
        check("rst_req_ready", {ifu_if.req_ready, lsu_if.req_ready}, 2'b00);
        rst = 1'b1;

        // Tie right after reset goes to IFU, then alternates while both stay valid
        ifu_if.req_valid = 1'b1; ifu_if.req_addr = 32'h0000_1000;
        lsu_if.req_valid = 1'b1; lsu_if.req_addr = 32'h0000_2000;
        check_grants("tie1", 1'b1, 1'b0);
        xact("tie1", 1'b0, 32'h0000_1000, 32'h1111_1111);
        check_grants("tie2", 1'b0, 1'b1);
        xact("tie2", 1'b1, 32'h0000_2000, 32'h2222_2222);
        check_grants("tie3", 1'b1, 1'b0);
        xact("tie3", 1'b0, 32'h0000_1000, 32'h3333_3333);
        ifu_if.req_valid = 1'b0;
        lsu_if.req_valid = 1'b0;

        // IFU-only read with write fields driven to junk; memory answers 2 cycles later
        mon_lsu = 1'b1;
        ifu_if.req_valid = 1'b1; ifu_if.req_addr = 32'h8000_0000;
        ifu_if.req_wen = 1'b1; ifu_if.req_wdata = 32'hFFFF_FFFF; ifu_if.req_wmask = 4'hF;
        check_grants("ifu", 1'b1, 1'b0);
        step();
        ifu_if.req_valid = 1'b0;
        #1;
        check("ifu_req_valid", mem_if.req_valid, 1'b1);
        check("ifu_req_addr", mem_if.req_addr, 32'h8000_0000);
        check("ifu_req_wen", mem_if.req_wen, 1'b0);
        check("ifu_req_wmask", mem_if.req_wmask, 4'h0);
        check("ifu_req_wdata", mem_if.req_wdata, 32'h0);
        mem_if.req_ready = 1'b1;
        step();
        mem_if.req_ready = 1'b0;
        check("ifu_req_drop", mem_if.req_valid, 1'b0);
        check("ifu_resp_wait", ifu_if.resp_valid, 1'b0);
        step();
        mem_if.resp_valid = 1'b1; mem_if.resp_rdata = 32'hDEAD_BEEF;
        #1;
        check("ifu_resp_valid", ifu_if.resp_valid, 1'b1);
        check("ifu_resp_rdata", ifu_if.resp_rdata, 32'hDEAD_BEEF);
        check("ifu_mem_resp_ready", mem_if.resp_ready, 1'b1);
        step();
        mem_if.resp_valid = 1'b0;
        ifu_if.req_wen = 1'b0; ifu_if.req_wdata = '0; ifu_if.req_wmask = '0;
        #1;
        check("ifu_lsu_never_valid", lsu_seen, 1'b0);
        mon_lsu = 1'b0;

        // LSU write with memory stalling 3 cycles; payload must hold
        lsu_if.req_valid = 1'b1; lsu_if.req_addr = 32'h8000_0100; lsu_if.req_wen = 1'b1;
        lsu_if.req_wdata = 32'h1234_5678; lsu_if.req_wmask = 4'hF;
        check_grants("wr", 1'b0, 1'b1);
        step();
        lsu_if.req_valid = 1'b0; lsu_if.req_addr = 32'hBAD0_BAD0;
        lsu_if.req_wdata = 32'h0BAD_F00D; lsu_if.req_wmask = 4'h3; lsu_if.req_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("wr_stall%0d_valid", i), mem_if.req_valid, 1'b1);
            check($sformatf("wr_stall%0d_payload", i),
                  {mem_if.req_addr, mem_if.req_wdata},
                  {32'h8000_0100, 32'h1234_5678});
            check($sformatf("wr_stall%0d_wen_mask", i),
                  {mem_if.req_wen, mem_if.req_wmask}, 5'h1F);
            if (i == 3) mem_if.req_ready = 1'b1;
            step();
        end
        mem_if.req_ready = 1'b0;
        check("wr_req_done", mem_if.req_valid, 1'b0);
        mem_if.resp_valid = 1'b1; mem_if.resp_rdata = 32'h0;
        #1;
        check("wr_resp_valid", {lsu_if.resp_valid, ifu_if.resp_valid}, 2'b10);
        step();
        mem_if.resp_valid = 1'b0;

        // Response backpressure from IFU; LSU waits meanwhile
        ifu_if.req_valid = 1'b1; ifu_if.req_addr = 32'h0000_3000;
        check_grants("bp", 1'b1, 1'b0);
        step();
        ifu_if.req_valid = 1'b0;
        mem_if.req_ready = 1'b1;
        step();
        mem_if.req_ready = 1'b0;
        lsu_if.req_valid = 1'b1; lsu_if.req_addr = 32'h0000_6000;
        ifu_if.resp_ready = 1'b0;
        mem_if.resp_valid = 1'b1; mem_if.resp_rdata = 32'hCAFE_0001;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("bp%0d_mem_resp_ready", i), mem_if.resp_ready, 1'b0);
            check($sformatf("bp%0d_ifu_resp_valid", i), ifu_if.resp_valid, 1'b1);
            check($sformatf("bp%0d_req_ready", i), {ifu_if.req_ready, lsu_if.req_ready}, 2'b00);
            check($sformatf("bp%0d_req_valid", i), mem_if.req_valid, 1'b0);
            step();
        end
        ifu_if.resp_ready = 1'b1;
        #1;
        check("bp_release", mem_if.resp_ready, 1'b1);
        step();
        mem_if.resp_valid = 1'b0;
        // LSU wins now but withdraws before the edge: nothing is captured
        check_grants("withdraw", 1'b0, 1'b1);
        lsu_if.req_valid = 1'b0;
        step();
        check("withdraw_no_req", mem_if.req_valid, 1'b0);

        // Async reset in RESP drops the transaction
        ifu_if.req_valid = 1'b1; ifu_if.req_addr = 32'h0000_4000;
        step();
        mem_if.req_ready = 1'b1;
        ifu_if.req_addr = 32'h0000_5000;
        step();
        mem_if.req_ready = 1'b0;
        mem_if.resp_valid = 1'b1; mem_if.resp_rdata = 32'h5A5A_5A5A;
        #1;
        check("ar_resp_before", ifu_if.resp_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_resp_valid", {ifu_if.resp_valid, lsu_if.resp_valid}, 2'b00);
        check("ar_mem_handshake", {mem_if.resp_ready, mem_if.req_valid}, 2'b00);
        mem_if.resp_valid = 1'b0;
        step();
        rst = 1'b1;
        check_grants("ar_after", 1'b1, 1'b0);
        check("ar_no_stale", ifu_if.resp_valid, 1'b0);
        xact("ar_new", 1'b0, 32'h0000_5000, 32'h7777_7777);
        ifu_if.req_valid = 1'b0;

        // Spurious memory response in IDLE is ignored
        mem_if.resp_valid = 1'b1; mem_if.resp_rdata = 32'hFFFF_0000;
        #1;
        check("spur_mem_resp_ready", mem_if.resp_ready, 1'b0);
        check("spur_resp_valid", {ifu_if.resp_valid, lsu_if.resp_valid}, 2'b00);
        step();
        check("spur_still_idle", mem_if.req_valid, 1'b0);
        check("spur_resp_valid2", {ifu_if.resp_valid, lsu_if.resp_valid}, 2'b00);
        mem_if.resp_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
